pqc_acc_seq: RTL
================

# pqc_acc_seq

Sequencer for the NTT and PWAM accelerators, which are launched by custom-0 PQC instructions (Opcode 0001011, Funct3 011). It accepts an accelerator instruction from decode and stalls the core. It then pulses the matching accelerator's start, counts the result beats the accelerator streams back, and drives the write-back address. It also produces the `ntt_valid` / `pwam_valid` qualifiers that the DMEM address/data select logic consumes. The block sits between the decode stage and the accelerators, on the DMEM write-back path.

## Interface
Parameters:
- `N_COEF`, 256, coefficients per operation; power of two, at least 2.
- `ADDR_W`, 32, DMEM byte-address width.
- `CNT_W`, 8, beat counter width; equals log2(`N_COEF`).

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: the decode stage holds a valid instruction this cycle.
- `Opcode` in 7: instruction opcode.
- `Funct3` in 3: instruction funct3.
- `Funct7` in 7: instruction funct7.
- `rs1_val` in `ADDR_W`: write-back base byte address.
- `res_valid` in 1: the active accelerator presents one result coefficient this cycle.
- `stall` out 1: freezes the core pipeline.
- `ntt_start` out 1: one-cycle NTT launch pulse.
- `ntt_inverse` out 1: NTT direction, 1 = inverse; held for the whole operation.
- `pwam_start` out 1: one-cycle PWAM launch pulse.
- `pwam_mode` out 2: PWAM sub-op (0, 1 or 2); held for the whole operation.
- `ntt_valid` out 1: an NTT result write is occurring this cycle.
- `pwam_valid` out 1: a PWAM result write is occurring this cycle.
- `acc_wr_addr` out `ADDR_W`: DMEM write address for the current beat.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **Accelerator hit:** `instr_valid` && Opcode == 0001011 && Funct3 == 011 && Funct7 is in {0000011, 0000100, 0000101, 0000110, 0000111}.
  - 0000011 selects forward NTT.
  - 0000100 selects inverse NTT.
  - 0000101, 0000110 and 0000111 select PWAM with mode = Funct7 − 5, giving 0, 1 and 2.
- **Not a hit:** Funct7 values 0000000–0000010, all other Funct7 values, and all other opcodes are not hits. The block ignores them and raises no stall.
- **IDLE:**
  - On a hit, latch the op type, `ntt_inverse`/`pwam_mode`, and `rs1_val` into `base_reg`.
  - Clear `cnt` and go to LAUNCH.
- **LAUNCH:**
  - Assert `ntt_start` for an NTT op, or `pwam_start` for a PWAM op, for exactly this cycle.
  - Go to STREAM.
- **STREAM:**
  - On each `res_valid`, assert `ntt_valid` or `pwam_valid` (matching the op) combinationally in the same cycle, and drive `acc_wr_addr` = `base_reg` + (`cnt` << 2).
  - `cnt` increments after each beat.
  - The beat taken while `cnt` == `N_COEF`−1 moves the FSM to DONE, and `cnt` wraps to 0.
- **DONE:** one cycle, then return to IDLE.
- **`stall`:** `(state != IDLE) || hit-in-IDLE`.
  - The hit term is combinational, so the instruction is frozen in the same cycle it is accepted.
  - `stall` stays high through DONE and drops in the first IDLE cycle.
- **Address arithmetic:** computed modulo 2^`ADDR_W`. Wrap-around past the top of the address space is permitted and is not flagged.
- **Out-of-state `res_valid`:** ignored in IDLE, LAUNCH and DONE. No valid is asserted and `cnt` does not change.
- **Hits while busy:** ignored. The core is stalled, so the instruction is re-presented after release.
- **Idle output values:** outside STREAM, `acc_wr_addr` = `base_reg`.
- **Reset (including mid-operation):** state = IDLE, `cnt` = 0, `base_reg` = 0, `ntt_inverse` = 0, `pwam_mode` = 0. With reset asserted and no hit presented, all outputs are 0 (`stall`, `busy`, both starts, both valids, `acc_wr_addr`). An accelerator left mid-operation is not the block's concern; later `res_valid` beats are ignored.

## Timing
- **Hit to start:** hit accepted at edge T, `ntt_start`/`pwam_start` high in cycle T+1, STREAM from T+2.
- **First beat:** can occur at the earliest in cycle T+2.
- **Beat throughput:** one beat per cycle; `res_valid` may be held continuously.
- **Gaps:** any number of idle cycles between beats is allowed.
- **Minimum operation:** `N_COEF` + 3 cycles from accept to the first IDLE cycle, i.e. `stall` high for `N_COEF` + 3 cycles.
- **Back-to-back:** a new hit is accepted in the first IDLE cycle after DONE.

## Test plan
- **Reset values:** reset asserted mid-STREAM at beat 100 → outputs go to 0 immediately; after release, 5 `res_valid` pulses produce no valids.
- **Forward NTT:** Funct7 = 0000011, `rs1_val` = 0x1000, `res_valid` held high.
  - `ntt_start` is high for 1 cycle at T+1, and `ntt_inverse` = 0.
  - 256 `ntt_valid` beats with addresses 0x1000…0x13FC.
  - `stall` is high for 259 cycles, and `pwam_valid` never rises.
- **PWAM modes:** Funct7 = 0000111 with random 0–3 cycle gaps between beats → `pwam_mode` = 2, exactly 256 `pwam_valid` beats, addresses contiguous. Repeat with Funct7 = 0000101 → `pwam_mode` = 0.
- **Non-hits and gating:**
  - Funct7 = 0000001, Funct7 = 0000010, and Funct3 = 010 with Funct7 = 0000011 → no `stall`, no start pulse.
  - `res_valid` asserted in IDLE or LAUNCH → no valid asserted, `cnt` unchanged.
- **Address wrap:** `rs1_val` = 0xFFFFFFF8 with `ADDR_W` = 32 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, …
- **Back-to-back and busy hits:**
  - An inverse NTT hit presented in the first IDLE cycle after a PWAM op is accepted, and `ntt_inverse` = 1.
  - A hit presented during STREAM causes no second start pulse.

Source files
------------

// File: rtl/pqc_acc_seq.sv
// Sequencer for the NTT/PWAM accelerators: launches an op on a custom-0 hit,
// stalls the core, counts result beats and drives the DMEM write-back address.
module pqc_acc_seq #(
    parameter int N_COEF = 256,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [6:0]        Opcode,
    input  logic [2:0]        Funct3,
    input  logic [6:0]        Funct7,
    input  logic [ADDR_W-1:0] rs1_val,
    input  logic              res_valid,
    output logic              stall,
    output logic              ntt_start,
    output logic              ntt_inverse,
    output logic              pwam_start,
    output logic [1:0]        pwam_mode,
    output logic              ntt_valid,
    output logic              pwam_valid,
    output logic [ADDR_W-1:0] acc_wr_addr,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_STREAM,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic              r_is_pwam;
    logic              r_inverse;
    logic [1:0]        r_mode;

    logic              w_hit;
    logic              w_f7_ntt;
    logic              w_idle;
    logic              w_stream;
    logic              w_beat;
    logic [ADDR_W-1:0] w_off;

    assign w_f7_ntt = (Funct7 == 7'd3) || (Funct7 == 7'd4);
    assign w_hit    = instr_valid && (Opcode == 7'b0001011)
                      && (Funct3 == 3'b011)
                      && (Funct7 >= 7'd3) && (Funct7 <= 7'd7);

    assign w_idle   = (r_state == S_IDLE);
    assign w_stream = (r_state == S_STREAM);
    assign w_beat   = w_stream && res_valid;
    // Byte offset of the current beat: one 32-bit word per coefficient.
    assign w_off    = {{(ADDR_W-CNT_W-2){1'b0}}, r_cnt, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_base    <= '0;
            r_is_pwam <= 1'b0;
            r_inverse <= 1'b0;
            r_mode    <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_is_pwam <= !w_f7_ntt;
                        r_inverse <= (Funct7 == 7'd4);
                        r_mode    <= w_f7_ntt ? 2'd0 : 2'(Funct7 - 7'd5);
                        r_base    <= rs1_val;
                        r_cnt     <= '0;
                        r_state   <= S_LAUNCH;
                    end
                end
                S_LAUNCH: r_state <= S_STREAM;
                S_STREAM: begin
                    if (res_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(N_COEF - 1)) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = !w_idle;
    assign stall       = !w_idle || w_hit;
    assign ntt_start   = (r_state == S_LAUNCH) && !r_is_pwam;
    assign pwam_start  = (r_state == S_LAUNCH) && r_is_pwam;
    assign ntt_valid   = w_beat && !r_is_pwam;
    assign pwam_valid  = w_beat && r_is_pwam;
    assign ntt_inverse = r_inverse;
    assign pwam_mode   = r_mode;
    assign acc_wr_addr = w_stream ? (r_base + w_off) : r_base;

endmodule
